isdu_waitstate: RTL and testbench

ISDU_WAITSTATE -- requirements
Module: isdu_waitstate

---
 rtl/isdu_waitstate.sv | 276 +++++++++++++++++++++++++++
 tb/tb_isdu_waitstate.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isdu_waitstate.sv
// LC-3 style control sequencer with a parameterised SRAM wait-state counter.
// Read and write cycles hold their memory strobe for exactly MEM_WAIT clocks.
module isdu_waitstate #(
  parameter int unsigned MEM_WAIT = 3,
  parameter bit          PAUSE_EN = 1'b1
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE,
  output logic [3:0] Wait_cnt
);

  typedef enum logic [4:0] {
    StHalted,
    StFetch,
    StRdWait,
    StLoadIr,
    StDecode,
    StAdd,
    StAnd,
    StNot,
    StBr,
    StBrTaken,
    StJmp,
    StJsr,
    StJsrPc,
    StLdrAddr,
    StWrWait,
    StLdrWb,
    StStrAddr,
    StStrMdr,
    StPause1,
    StPause2
  } state_e;

  localparam logic [3:0] OpBr    = 4'b0000;
  localparam logic [3:0] OpAdd   = 4'b0001;
  localparam logic [3:0] OpJsr   = 4'b0100;
  localparam logic [3:0] OpAnd   = 4'b0101;
  localparam logic [3:0] OpLdr   = 4'b0110;
  localparam logic [3:0] OpStr   = 4'b0111;
  localparam logic [3:0] OpNot   = 4'b1001;
  localparam logic [3:0] OpJmp   = 4'b1100;
  localparam logic [3:0] OpPause = 4'b1101;

  // Counter counts down to zero, so a MEM_WAIT-cycle access starts at MEM_WAIT-1.
  localparam logic [3:0] WaitLoad = 4'(MEM_WAIT - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  // Return tag for RD_WAIT: 0 -> LOAD_IR (instruction fetch), 1 -> LDR_WB (data load).
  logic       ret_wb_q, ret_wb_d;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= StHalted;
      cnt_q    <= 4'd0;
      ret_wb_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ret_wb_q <= ret_wb_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ret_wb_d = ret_wb_q;
    unique case (state_q)
      StHalted: begin
        if (Run) state_d = StFetch;
      end
      StFetch: begin
        state_d  = StRdWait;
        cnt_d    = WaitLoad;
        ret_wb_d = 1'b0;
      end
      StRdWait: begin
        if (cnt_q == 4'd0) begin
          state_d = ret_wb_q ? StLdrWb : StLoadIr;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StLoadIr: state_d = StDecode;
      StDecode: begin
        case (Opcode)
          OpAdd:   state_d = StAdd;
          OpAnd:   state_d = StAnd;
          OpNot:   state_d = StNot;
          OpBr:    state_d = StBr;
          OpJmp:   state_d = StJmp;
          OpJsr:   state_d = StJsr;
          OpLdr:   state_d = StLdrAddr;
          OpStr:   state_d = StStrAddr;
          OpPause: state_d = PAUSE_EN ? StPause1 : StFetch;
          default: state_d = StFetch;
        endcase
      end
      StAdd, StAnd, StNot, StJmp, StBrTaken, StJsrPc, StLdrWb: begin
        state_d = StFetch;
      end
      StBr: begin
        state_d = BEN ? StBrTaken : StFetch;
      end
      StJsr: state_d = StJsrPc;
      StLdrAddr: begin
        state_d  = StRdWait;
        cnt_d    = WaitLoad;
        ret_wb_d = 1'b1;
      end
      StStrAddr: state_d = StStrMdr;
      StStrMdr: begin
        state_d = StWrWait;
        cnt_d   = WaitLoad;
      end
      StWrWait: begin
        if (cnt_q == 4'd0) begin
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StPause1: begin
        if (Continue) state_d = StPause2;
      end
      // Wait for release so a held button executes only one instruction.
      StPause2: begin
        if (!Continue) state_d = StFetch;
      end
      default: begin
        state_d  = StHalted;
        cnt_d    = 4'd0;
        ret_wb_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    SR2MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b0;
    Mem_WE     = 1'b0;
    unique case (state_q)
      StFetch: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        LD_PC  = 1'b1;
        PCMUX  = 2'b00;
      end
      StRdWait: begin
        Mem_OE = 1'b1;
        LD_MDR = (cnt_q == 4'd0);
      end
      StLoadIr: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      StDecode: LD_BEN = 1'b1;
      StAdd, StAnd, StNot: begin
        SR1MUX  = 1'b1;
        SR2MUX  = (state_q == StNot) ? 1'b0 : IR_5;
        ALUK    = (state_q == StAdd) ? 2'b00 : ((state_q == StAnd) ? 2'b01 : 2'b10);
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        DRMUX   = 1'b0;
      end
      StBrTaken: begin
        PCMUX    = 2'b10;
        ADDR1MUX = 1'b0;
        ADDR2MUX = 2'b10;
        LD_PC    = 1'b1;
      end
      StJmp: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        PCMUX   = 2'b01;
        LD_PC   = 1'b1;
      end
      StJsr: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      StJsrPc: begin
        LD_PC = 1'b1;
        if (IR_11) begin
          PCMUX    = 2'b10;
          ADDR1MUX = 1'b0;
          ADDR2MUX = 2'b11;
        end else begin
          PCMUX  = 2'b01;
          SR1MUX = 1'b1;
          ALUK   = 2'b11;
        end
      end
      StLdrAddr, StStrAddr: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      StLdrWb: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
        DRMUX   = 1'b0;
      end
      StStrMdr: begin
        SR1MUX  = 1'b0;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      StWrWait: Mem_WE = 1'b1;
      StPause1: LD_LED = 1'b1;
      default: ;
    endcase
  end

  assign Wait_cnt = cnt_q;

  a_mem_excl: assert property (@(posedge Clk) disable iff (!Reset_n) !(Mem_OE && Mem_WE));
  a_one_gate: assert property (@(posedge Clk) disable iff (!Reset_n)
    $onehot0({GatePC, GateMDR, GateALU, GateMARMUX}));
  a_cnt_idle: assert property (@(posedge Clk) disable iff (!Reset_n)
    (state_q != StRdWait && state_q != StWrWait) |-> (cnt_q == 4'd0));

endmodule

// File: tb/tb_isdu_waitstate.sv
// Scoreboard bench for isdu_waitstate: three instances cover MEM_WAIT 3/5/1 and PAUSE_EN 1/1/0.
module tb_isdu_waitstate;

  logic       Clk = 1'b0;
  logic       Reset_n, Run, Continue, IR_5, IR_11, BEN;
  logic [3:0] Opcode;
  logic [2:0][23:0] ctl_o;
  logic [2:0][3:0]  wcnt_o;

  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    isdu_waitstate #(
      .MEM_WAIT(g == 0 ? 3 : (g == 1 ? 5 : 1)),
      .PAUSE_EN(g != 2)
    ) u_dut (
      .Clk(Clk), .Reset_n(Reset_n), .Run(Run), .Continue(Continue), .Opcode(Opcode),
      .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
      .LD_MAR(ctl_o[g][23]), .LD_MDR(ctl_o[g][22]), .LD_IR(ctl_o[g][21]),
      .LD_BEN(ctl_o[g][20]), .LD_CC(ctl_o[g][19]), .LD_REG(ctl_o[g][18]),
      .LD_PC(ctl_o[g][17]), .LD_LED(ctl_o[g][16]), .GatePC(ctl_o[g][15]),
      .GateMDR(ctl_o[g][14]), .GateALU(ctl_o[g][13]), .GateMARMUX(ctl_o[g][12]),
      .PCMUX(ctl_o[g][11:10]), .DRMUX(ctl_o[g][9]), .SR1MUX(ctl_o[g][8]),
      .SR2MUX(ctl_o[g][7]), .ADDR1MUX(ctl_o[g][6]), .ADDR2MUX(ctl_o[g][5:4]),
      .ALUK(ctl_o[g][3:2]), .Mem_OE(ctl_o[g][1]), .Mem_WE(ctl_o[g][0]),
      .Wait_cnt(wcnt_o[g])
    );
  end

  typedef struct packed {
    logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc, ld_led;
    logic gate_pc, gate_mdr, gate_alu, gate_marmux;
    logic [1:0] pcmux;
    logic drmux, sr1mux, sr2mux, addr1mux;
    logic [1:0] addr2mux, aluk;
    logic mem_oe, mem_we;
  } ctl_t;

  typedef enum int {
    SHalted, SFetch, SRdWait, SLoadIr, SDecode, SAdd, SAnd, SNot, SBr, SBrTaken, SJmp,
    SJsr, SJsrPc, SLdrAddr, SWrWait, SLdrWb, SStrAddr, SStrMdr, SPause1, SPause2
  } tst_e;

  typedef struct {
    tst_e       st;
    logic [3:0] w;
    logic       run, cont, ben, ir5, ir11;
    logic [3:0] op;
  } item_t;

  item_t      sb[$];
  int         checks = 0;
  int         failures = 0;
  logic [3:0] cur_op;
  logic       cur_run, cur_ben, cur_ir5, cur_ir11;

  function automatic void push(tst_e st, logic [3:0] w = 4'd0, logic cont = 1'b0);
    item_t it;
    it.st = st; it.w = w; it.cont = cont; it.run = cur_run; it.op = cur_op;
    it.ben = cur_ben; it.ir5 = cur_ir5; it.ir11 = cur_ir11;
    sb.push_back(it);
  endfunction

  function automatic void push_read(int mw);
    for (int k = mw - 1; k >= 0; k--) push(SRdWait, 4'(k));
  endfunction

  function automatic void push_write(int mw);
    for (int k = mw - 1; k >= 0; k--) push(SWrWait, 4'(k));
  endfunction

  function automatic void push_fetch(int mw);
    push(SFetch);
    push_read(mw);
    push(SLoadIr);
    push(SDecode);
  endfunction

  // Reference control word for each state, taken from the state table.
  function automatic ctl_t exp_ctl(item_t it);
    ctl_t c = '0;
    case (it.st)
      SFetch:   begin c.gate_pc = 1; c.ld_mar = 1; c.ld_pc = 1; end
      SRdWait:  begin c.mem_oe = 1; c.ld_mdr = (it.w == 4'd0); end
      SLoadIr:  begin c.gate_mdr = 1; c.ld_ir = 1; end
      SDecode:  c.ld_ben = 1;
      SAdd, SAnd, SNot: begin
        c.sr1mux = 1; c.gate_alu = 1; c.ld_reg = 1; c.ld_cc = 1;
        c.sr2mux = (it.st == SNot) ? 1'b0 : it.ir5;
        c.aluk = (it.st == SAdd) ? 2'd0 : ((it.st == SAnd) ? 2'd1 : 2'd2);
      end
      SBrTaken: begin c.pcmux = 2'd2; c.addr2mux = 2'd2; c.ld_pc = 1; end
      SJmp:     begin c.sr1mux = 1; c.aluk = 2'd3; c.gate_alu = 1; c.pcmux = 2'd1; c.ld_pc = 1; end
      SJsr:     begin c.gate_pc = 1; c.drmux = 1; c.ld_reg = 1; end
      SJsrPc: begin
        c.ld_pc = 1;
        if (it.ir11) begin c.pcmux = 2'd2; c.addr2mux = 2'd3; end
        else begin c.pcmux = 2'd1; c.sr1mux = 1; c.aluk = 2'd3; end
      end
      SLdrAddr, SStrAddr: begin
        c.sr1mux = 1; c.addr1mux = 1; c.addr2mux = 2'd1; c.gate_marmux = 1; c.ld_mar = 1;
      end
      SLdrWb:   begin c.gate_mdr = 1; c.ld_reg = 1; c.ld_cc = 1; end
      SStrMdr:  begin c.aluk = 2'd3; c.gate_alu = 1; c.ld_mdr = 1; end
      SWrWait:  c.mem_we = 1;
      SPause1:  c.ld_led = 1;
      default:  ;
    endcase
    return c;
  endfunction

  task automatic drive(item_t it);
    Run = it.run; Continue = it.cont; Opcode = it.op; BEN = it.ben;
    IR_5 = it.ir5; IR_11 = it.ir11;
    #1;
  endtask

  task automatic do_reset();
    @(negedge Clk);
    Reset_n = 1'b0; Run = 1'b0; Continue = 1'b0; Opcode = 4'd0; BEN = 1'b0;
    IR_5 = 1'b0; IR_11 = 1'b0;
    cur_op = 4'd0; cur_run = 1'b0; cur_ben = 1'b0; cur_ir5 = 1'b0; cur_ir11 = 1'b0;
    sb.delete();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic test_reset();
    item_t it;
    ctl_t  exp;
    do_reset();
    repeat (3) push(SHalted);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      for (int s = 0; s < 3; s++) begin
        checks++;
        if (ctl_t'(ctl_o[s]) !== exp) begin
          failures++;
          $display("FAIL reset dut%0d ctl=%h expected %h", s, ctl_o[s], exp);
        end
        checks++;
        if (wcnt_o[s] !== it.w) begin
          failures++;
          $display("FAIL reset dut%0d wait_cnt=%0d expected %0d", s, wcnt_o[s], it.w);
        end
      end
      @(negedge Clk);
    end
  endtask

  task automatic test_add();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_op = 4'b0001; cur_ir5 = 1'b1;
    cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
    push_fetch(3); push(SAdd); push(SFetch);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      checks++;
      if (ctl_t'(ctl_o[0]) !== exp) begin
        failures++;
        $display("FAIL add c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[0], exp);
      end
      checks++;
      if (wcnt_o[0] !== it.w) begin
        failures++;
        $display("FAIL add c%0d wait_cnt=%0d expected %0d", n, wcnt_o[0], it.w);
      end
      @(negedge Clk); n++;
    end
  endtask

  // AND, NOT, JMP consecutively with Run held high to show it is ignored once running.
  task automatic test_back_to_back();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_run = 1'b1;
    push(SHalted);
    cur_op = 4'b0101; cur_ir5 = 1'b0; push_fetch(3); push(SAnd);
    cur_op = 4'b1001; cur_ir5 = 1'b1; push_fetch(3); push(SNot);
    cur_op = 4'b1100; push_fetch(3); push(SJmp); push(SFetch);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      checks++;
      if (ctl_t'(ctl_o[0]) !== exp) begin
        failures++;
        $display("FAIL b2b c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[0], exp);
      end
      checks++;
      if (wcnt_o[0] !== it.w) begin
        failures++;
        $display("FAIL b2b c%0d wait_cnt=%0d expected %0d", n, wcnt_o[0], it.w);
      end
      @(negedge Clk); n++;
    end
  endtask

  task automatic test_store_wait5();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_op = 4'b0111;
    cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
    push_fetch(5); push(SStrAddr); push(SStrMdr); push_write(5); push(SFetch);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      checks++;
      if (ctl_t'(ctl_o[1]) !== exp) begin
        failures++;
        $display("FAIL store c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[1], exp);
      end
      checks++;
      if (wcnt_o[1] !== it.w) begin
        failures++;
        $display("FAIL store c%0d wait_cnt=%0d expected %0d", n, wcnt_o[1], it.w);
      end
      @(negedge Clk); n++;
    end
  endtask

  task automatic test_load_wait1();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_op = 4'b0110;
    cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
    push_fetch(1); push(SLdrAddr); push_read(1); push(SLdrWb); push(SFetch);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      checks++;
      if (ctl_t'(ctl_o[2]) !== exp) begin
        failures++;
        $display("FAIL load c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[2], exp);
      end
      checks++;
      if (wcnt_o[2] !== it.w) begin
        failures++;
        $display("FAIL load c%0d wait_cnt=%0d expected %0d", n, wcnt_o[2], it.w);
      end
      @(negedge Clk); n++;
    end
  endtask

  // BR not taken, BR taken, JSR (PC-relative), JSRR, then an unused opcode.
  task automatic test_branch_jsr();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_op = 4'b0000;
    cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
    push_fetch(3); push(SBr);
    cur_ben = 1'b1; push_fetch(3); push(SBr); push(SBrTaken);
    cur_ben = 1'b0; cur_op = 4'b0100; cur_ir11 = 1'b1; push_fetch(3); push(SJsr); push(SJsrPc);
    cur_ir11 = 1'b0; push_fetch(3); push(SJsr); push(SJsrPc);
    cur_op = 4'b1111; push_fetch(3); push(SFetch);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      checks++;
      if (ctl_t'(ctl_o[0]) !== exp) begin
        failures++;
        $display("FAIL branch c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[0], exp);
      end
      checks++;
      if (wcnt_o[0] !== it.w) begin
        failures++;
        $display("FAIL branch c%0d wait_cnt=%0d expected %0d", n, wcnt_o[0], it.w);
      end
      @(negedge Clk); n++;
    end
  endtask

  task automatic test_pause();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_op = 4'b1101;
    cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
    push_fetch(3); push(SPause1); push(SPause1, 4'd0, 1'b1);
    repeat (3) push(SPause2, 4'd0, 1'b1);
    push(SPause2); push(SFetch);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      checks++;
      if (ctl_t'(ctl_o[0]) !== exp) begin
        failures++;
        $display("FAIL pause c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[0], exp);
      end
      checks++;
      if (wcnt_o[0] !== it.w) begin
        failures++;
        $display("FAIL pause c%0d wait_cnt=%0d expected %0d", n, wcnt_o[0], it.w);
      end
      @(negedge Clk); n++;
    end
  endtask

  task automatic test_pause_disabled();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_op = 4'b1101;
    cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
    push_fetch(1); push(SFetch, 4'd0, 1'b1);
    while (sb.size() > 0) begin
      it = sb.pop_front();
      drive(it);
      exp = exp_ctl(it);
      checks++;
      if (ctl_t'(ctl_o[2]) !== exp) begin
        failures++;
        $display("FAIL nopause c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[2], exp);
      end
      checks++;
      if (wcnt_o[2] !== it.w) begin
        failures++;
        $display("FAIL nopause c%0d wait_cnt=%0d expected %0d", n, wcnt_o[2], it.w);
      end
      @(negedge Clk); n++;
    end
  endtask

  // Reset asserted during the second read-wait cycle must kill Mem_OE at once.
  task automatic test_reset_abort();
    item_t it;
    ctl_t  exp;
    int    n = 0;
    do_reset();
    cur_op = 4'b0001;
    cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
    push(SFetch); push(SRdWait, 4'd2); push(SRdWait, 4'd1);
    for (int phase = 0; phase < 2; phase++) begin
      while (sb.size() > 0) begin
        it = sb.pop_front();
        drive(it);
        exp = exp_ctl(it);
        checks++;
        if (ctl_t'(ctl_o[0]) !== exp) begin
          failures++;
          $display("FAIL abort c%0d %s ctl=%h expected %h", n, it.st.name(), ctl_o[0], exp);
        end
        checks++;
        if (wcnt_o[0] !== it.w) begin
          failures++;
          $display("FAIL abort c%0d wait_cnt=%0d expected %0d", n, wcnt_o[0], it.w);
        end
        n++;
        if (phase == 0 && sb.size() == 0) break;
        @(negedge Clk);
      end
      if (phase == 0) begin
        Reset_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
          #1;
          checks++;
          if (ctl_o[0] !== 24'h0 || wcnt_o[0] !== 4'd0) begin
            failures++;
            $display("FAIL abort held%0d ctl=%h wait_cnt=%0d expected 0/0", k, ctl_o[0], wcnt_o[0]);
          end
          @(negedge Clk);
        end
        Reset_n = 1'b1;
        push(SHalted); push(SHalted);
        cur_run = 1'b1; push(SHalted); cur_run = 1'b0;
        push(SFetch); push(SRdWait, 4'd2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_store_wait5();
    test_load_wait1();
    test_branch_jsr();
    test_pause();
    test_pause_disabled();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
